// File: rtl/ram_timing_pkg.sv
// Shared timing definitions for the DRAM refresh path: refresh-state
// encoding and the default interval constants for a 25 MHz system clock.
package ram_timing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } ref_state_e;

    localparam int REF_PERIOD_25MHZ = 390;  // 15.6 us at 25 MHz
    localparam int URG_DELAY_DEF    = 128;
    localparam int MAX_DEBT_DEF     = 7;
    localparam int URG_DEBT_DEF     = 2;

endpackage

// File: rtl/ref_prescaler.sv
// Free-running modulo-PERIOD counter. tick_o is high for the one cycle in
// which the count sits at PERIOD-1, so the first tick is consumed on the
// PERIOD-th rising edge after reset is released.
module ref_prescaler #(
    parameter int PERIOD = 390,
    localparam int W     = $clog2(PERIOD)
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam logic [W-1:0] LAST = W'(PERIOD - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] cnt_q;

    assign tick_o = (cnt_q == LAST);

    // Count up and wrap to zero after the terminal value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + ONE;
        end
    end

endmodule

// File: rtl/ram_refresh_timer.sv
// Refresh request generator for the DRAM controller. Tracks a saturating
// count of owed refreshes (debt), raises RefReq while debt is owed, drops it
// for one cycle after each RefAck so the controller's done-latch re-arms,
// and escalates to RefUrg when a request has aged or debt has piled up.
module ram_refresh_timer
    import ram_timing_pkg::*;
#(
    parameter int REF_PERIOD = REF_PERIOD_25MHZ,
    parameter int URG_DELAY  = URG_DELAY_DEF,
    parameter int URG_DEBT   = URG_DEBT_DEF,
    parameter int MAX_DEBT   = MAX_DEBT_DEF,
    localparam int DW        = $clog2(MAX_DEBT + 1),
    localparam int AW        = $clog2(URG_DELAY + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          RefAck,
    output logic          RefReq,
    output logic          RefUrg,
    output logic          RefMiss,
    output logic [DW-1:0] RefDebt
);

    localparam logic [DW-1:0] DEBT_MAX = DW'(MAX_DEBT);
    localparam logic [DW-1:0] DEBT_URG = DW'(URG_DEBT);
    localparam logic [DW-1:0] DEBT_ONE = DW'(1);
    localparam logic [AW-1:0] AGE_MAX  = AW'(URG_DELAY);
    localparam logic [AW-1:0] AGE_ONE  = AW'(1);

    logic          tick;
    logic          ack_eff;
    ref_state_e    state_q, state_d;
    logic [DW-1:0] debt_q, debt_d;
    logic [AW-1:0] age_q, age_d;
    logic          miss_q, miss_d;
    logic          req_q, req_d;
    logic          urg_q, urg_d;

    ref_prescaler #(
        .PERIOD (REF_PERIOD)
    ) u_prescaler (
        .clk_i  (CLK),
        .rst_i  (RST),
        .tick_o (tick)
    );

    // Next-state logic: debt bookkeeping, request state and age counter.
    always_comb begin
        // An ack only retires debt when a request could have been outstanding;
        // acks in IDLE or with nothing owed are dropped entirely.
        ack_eff = RefAck && (state_q != IDLE) && (debt_q != '0);

        debt_d = debt_q;
        miss_d = miss_q;
        if (tick && !ack_eff) begin
            if (debt_q == DEBT_MAX) begin
                miss_d = 1'b1;
            end else begin
                debt_d = debt_q + DEBT_ONE;
            end
        end else if (ack_eff && !tick) begin
            debt_d = debt_q - DEBT_ONE;
        end

        state_d = state_q;
        age_d   = '0;
        case (state_q)
            // Raise the request one cycle after the tick that created debt.
            IDLE: begin
                if (debt_q != '0) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (RefAck) begin
                    state_d = GAP;
                end else if (age_q == AGE_MAX) begin
                    age_d = age_q;
                end else begin
                    age_d = age_q + AGE_ONE;
                end
            end
            // Look at post-update debt so a tick or ack landing in the gap
            // is reflected in where we go next.
            GAP: begin
                state_d = (debt_d != '0) ? REQ : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d = (state_d == REQ);
        urg_d = req_d && ((age_d == AGE_MAX) || (debt_d >= DEBT_URG));
    end

    // State and registered strobe outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            debt_q  <= '0;
            age_q   <= '0;
            miss_q  <= 1'b0;
            req_q   <= 1'b0;
            urg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            debt_q  <= debt_d;
            age_q   <= age_d;
            miss_q  <= miss_d;
            req_q   <= req_d;
            urg_q   <= urg_d;
        end
    end

    assign RefReq  = req_q;
    assign RefUrg  = urg_q;
    assign RefMiss = miss_q;
    assign RefDebt = debt_q;

endmodule

// File: tb/tb_ram_refresh_timer.sv
// Directed bench for ram_refresh_timer with default parameters. Each table
// row advances the clock a number of edges (RefAck optionally pulsed on the
// first edge) and then checks all outputs. Edge numbers in comments count
// rising edges since RST was released.
module tb_ram_refresh_timer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RefAck = 1'b0;
    logic       RefReq;
    logic       RefUrg;
    logic       RefMiss;
    logic [2:0] RefDebt;

    int n_checks = 0;
    int n_fails  = 0;

    ram_refresh_timer dut (
        .CLK     (CLK),
        .RST     (RST),
        .RefAck  (RefAck),
        .RefReq  (RefReq),
        .RefUrg  (RefUrg),
        .RefMiss (RefMiss),
        .RefDebt (RefDebt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          do_rst;  // async reset mid-cycle before this row
        int unsigned cycles;
        bit          ack;
        bit          req;
        bit          urg;
        bit          miss;
        int          debt;
    } step_t;

    step_t steps[$];

    function automatic void add(bit r, int unsigned c, bit a, bit q, bit u, bit m, int d);
        step_t s;
        s.do_rst = r; s.cycles = c; s.ack = a;
        s.req = q; s.urg = u; s.miss = m; s.debt = d;
        steps.push_back(s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit q, input bit u, input bit m, input int d);
        check({tag, "_req"},  int'(RefReq),  int'(q));
        check({tag, "_urg"},  int'(RefUrg),  int'(u));
        check({tag, "_miss"}, int'(RefMiss), int'(m));
        check({tag, "_debt"}, int'(RefDebt), d);
    endtask

    initial begin
        // Scenario 1: first tick at edge 390, request at 391, urgent by age at 519.
        add(0, 389, 0, 0, 0, 0, 0);   // 389
        add(0, 1,   0, 0, 0, 0, 1);   // 390 tick
        add(0, 1,   0, 1, 0, 0, 1);   // 391 RefReq rises
        add(0, 127, 0, 1, 0, 0, 1);   // 518 age 127
        add(0, 1,   0, 1, 1, 0, 1);   // 519 age 128 -> urgent
        // Scenario 2: ack retires the only debt, then IDLE; spurious ack ignored.
        add(0, 1,   1, 0, 0, 0, 0);   // 520 GAP
        add(0, 1,   0, 0, 0, 0, 0);   // 521 IDLE
        add(0, 1,   1, 0, 0, 0, 0);   // 522 ack in IDLE
        add(0, 258, 0, 0, 0, 0, 1);   // 780 second tick
        add(0, 1,   0, 1, 0, 0, 1);   // 781
        // Scenario 3: debt piles to 3, urgent at debt 2, three spaced acks.
        add(0, 389, 0, 1, 1, 0, 2);   // 1170
        add(0, 390, 0, 1, 1, 0, 3);   // 1560
        add(0, 1,   1, 0, 0, 0, 2);   // 1561 GAP
        add(0, 1,   0, 1, 1, 0, 2);   // 1562 REQ again
        add(0, 3,   0, 1, 1, 0, 2);   // 1565
        add(0, 1,   1, 0, 0, 0, 1);   // 1566 GAP
        add(0, 1,   0, 1, 0, 0, 1);   // 1567 REQ, age 0, debt 1
        add(0, 3,   0, 1, 0, 0, 1);   // 1570
        add(0, 1,   1, 0, 0, 0, 0);   // 1571 GAP
        add(0, 1,   0, 0, 0, 0, 0);   // 1572 IDLE
        // Scenario 4: eight unacked ticks saturate debt and set RefMiss.
        add(0, 378, 0, 0, 0, 0, 1);   // 1950
        add(0, 1,   0, 1, 0, 0, 1);   // 1951
        add(0, 389, 0, 1, 1, 0, 2);   // 2340
        add(0, 1950,0, 1, 1, 0, 7);   // 4290 seventh tick
        add(0, 390, 0, 1, 1, 1, 7);   // 4680 eighth tick -> miss
        add(0, 1,   1, 0, 0, 1, 6);   // 4681
        add(0, 1,   0, 1, 1, 1, 6);   // 4682
        for (int d = 5; d >= 2; d--) begin
            add(0, 1, 1, 0, 0, 1, d); // ack -> GAP
            add(0, 1, 0, 1, 1, 1, d); // back to REQ
        end                           // ends at 4690, debt 2
        // Scenario 5: ack coincident with tick at debt 2.
        add(0, 379, 0, 1, 1, 1, 2);   // 5069
        add(0, 1,   1, 0, 0, 1, 2);   // 5070 tick+ack -> GAP, debt kept
        add(0, 1,   0, 1, 1, 1, 2);   // 5071 REQ
        add(0, 1,   1, 0, 0, 1, 1);   // 5072 GAP
        add(0, 1,   0, 1, 0, 1, 1);   // 5073 REQ, age restarted
        add(0, 127, 0, 1, 0, 1, 1);   // 5200 age 127
        add(0, 1,   0, 1, 1, 1, 1);   // 5201 age 128
        // Scenario 6: async reset mid-REQ, then prescaler restarts from zero.
        add(1, 389, 0, 0, 0, 0, 0);   // 389 after release
        add(0, 1,   0, 0, 0, 0, 1);   // 390 tick
        add(0, 1,   0, 1, 0, 0, 1);   // 391 RefReq

        // Reset state.
        repeat (3) @(posedge CLK);
        #1;
        check_all("reset", 0, 0, 0, 0);
        RST = 1'b0;

        foreach (steps[i]) begin
            if (steps[i].do_rst) begin
                #3;
                RST = 1'b1;
                #1;
                check_all($sformatf("async_rst%0d", i), 0, 0, 0, 0);
                @(posedge CLK);
                #1;
                RST = 1'b0;
            end
            RefAck = steps[i].ack;
            for (int c = 0; c < int'(steps[i].cycles); c++) begin
                @(posedge CLK);
                #1;
                RefAck = 1'b0;
            end
            check_all($sformatf("step%0d", i), steps[i].req, steps[i].urg,
                      steps[i].miss, steps[i].debt);
            $display("step %0d: cycles=%0d ack=%0d -> req=%0d urg=%0d miss=%0d debt=%0d",
                     i, steps[i].cycles, steps[i].ack, RefReq, RefUrg, RefMiss, RefDebt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ram_refresh_timer.md
Name: ram_refresh_timer

Overview:
- Upstream neighbour of the DRAM controller. Generates the refresh request (RefReq) and urgent refresh (RefUrg) strobes that the controller samples as RefReqIn/RefUrgIn.
- Counts CLK cycles to the refresh interval and keeps a saturating count of owed refreshes ("debt"). Escalates to urgent on age or debt.
- Retires one debt unit per RefAck pulse, returned by the controller on entry to refresh RAS I.
- Drops RefReq for one cycle after each ack, so the controller's refresh-done latch re-arms.

Parameters:
- REF_PERIOD, 390: CLK cycles per refresh interval (15.6 us at 25 MHz); must be >= 2.
- URG_DELAY, 128: cycles a request may wait before RefUrg asserts.
- URG_DEBT, 2: debt at or above which RefUrg asserts immediately.
- MAX_DEBT, 7: debt saturation value; URG_DEBT <= MAX_DEBT.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- RefAck  in  1  one-cycle pulse from the controller when refresh RAS I begins.
- RefReq  out  1  refresh requested; registered.
- RefUrg  out  1  refresh urgent; registered; implies RefReq.
- RefMiss  out  1  sticky: a tick arrived while debt == MAX_DEBT.
- RefDebt  out  3  current debt, for debug/visibility; width = clog2(MAX_DEBT+1).

Behaviour:

Reset (RST = 1, asynchronous):
- Prescaler = 0, debt = 0, age = 0, state = IDLE.
- RefReq = 0, RefUrg = 0, RefMiss = 0, RefDebt = 0.

Prescaler:
- Counts 0..REF_PERIOD-1 and wraps.
- tick = (prescaler == REF_PERIOD-1).
- First tick occurs on the REF_PERIOD-th rising edge after RST deasserts.

Debt update, per edge:
- tick & !ack: debt + 1, saturating at MAX_DEBT. If debt was already MAX_DEBT, set RefMiss.
- ack & !tick: debt - 1. When debt == 0, an ack is ignored (no underflow).
- tick & ack: debt unchanged. When debt == 0, this case behaves as tick only (debt becomes 1).

States (RefReq/RefUrg are decoded from the registered state and age):
- IDLE: debt == 0. RefReq = 0, RefUrg = 0.
  - Goes to REQ when the new debt is > 0; age := 0.
- REQ: RefReq = 1. RefUrg = 1 when age == URG_DELAY or debt >= URG_DEBT.
  - age increments each cycle, saturating at URG_DELAY.
  - On ack: go to GAP; age := 0.
- GAP: exactly one cycle. RefReq = 0, RefUrg = 0.
  - Next state is REQ if debt > 0 (age := 0), otherwise IDLE.
  - A tick during GAP still increments debt.
  - An ack during GAP decrements debt but causes no additional state effect.

Output timing:
- RefReq rises on the edge after the tick edge, i.e. one cycle latency from the internal tick.
- RefUrg for age: asserts on the edge at which age reaches URG_DELAY, i.e. URG_DELAY cycles after RefReq rose.
- Ack in REQ: RefReq is low in the following cycle (GAP), then returns to 1 if debt remains.

Other rules:
- RefAck while in IDLE is ignored and causes no state change.
- RefMiss is cleared only by RST.
- RST mid-request drops RefReq/RefUrg immediately (asynchronous) and clears debt.
- All arithmetic is unsigned. Age counter width = clog2(URG_DELAY+1); prescaler width = clog2(REF_PERIOD).

Decomposition:
- Shared package ram_timing_pkg holds:
  - refresh-state enum (IDLE, REQ, GAP);
  - default constants REF_PERIOD_25MHZ = 390, URG_DELAY_DEF = 128, MAX_DEBT_DEF = 7, URG_DEBT_DEF = 2.
- One natural sub-module, ref_prescaler: free-running modulo-REF_PERIOD counter with a tick output.
- The debt/age/state logic stays in the top module.

Test Plan:
1. Release RST, no ack; REF_PERIOD = 390 -> RefReq rises on edge 391; RefUrg rises 128 cycles later; RefDebt = 1.
2. From scenario 1, pulse RefAck while RefReq = 1 -> next cycle RefReq = 0, RefDebt = 0, state IDLE; no reassert until next tick.
3. Withhold ack for 3 intervals -> RefDebt = 3, RefUrg = 1 immediately at debt 2. Three acks spaced 5 cycles apart -> RefReq shows a 1-cycle low after each ack, then ends at 0 with debt 0.
4. Withhold ack for 8 intervals -> RefDebt saturates at 7, RefMiss = 1 on the 8th tick and stays 1 through later acks until RST.
5. Ack coincident with a tick while debt = 2 -> RefDebt stays 2, GAP for one cycle, RefReq returns to 1 with age restarted at 0. Spurious ack in IDLE -> no change.
6. Assert RST asynchronously mid-REQ, between clock edges -> RefReq/RefUrg/RefDebt go to 0 before the next edge. After release, the first tick occurs 390 edges later.
